// File: rtl/parallelisering_pkg.sv
// Shared types for the four-lane SIMD arithmetic block.
// Element width, lane count and the lane operation selector.
package parallelisering_pkg;

    localparam int W     = 8;
    localparam int LANES = 4;

    typedef logic [W-1:0] elem_t;

    typedef enum logic [1:0] {
        OP_ADD,
        OP_MUL,
        OP_SUB
    } op_t;

endpackage

// File: rtl/parallelisering_core_lane_alu.sv
// Combinational single-lane ALU; the operation is fixed at elaboration.
// All results wrap modulo 2^W by truncation to the element width.
module lane_alu
    import parallelisering_pkg::*;
#(
    parameter op_t OP = OP_ADD
) (
    input  elem_t x,
    input  elem_t y,
    output elem_t r
);

    if (OP == OP_MUL) begin : g_mul
        assign r = x * y;
    end else if (OP == OP_SUB) begin : g_sub
        assign r = x - y;
    end else begin : g_add
        assign r = x + y;
    end

endmodule

// File: rtl/parallelisering_core.sv
// Four-lane SIMD add / multiply / subtract with a registered result bank.
// One result set per in_valid cycle, 1-cycle latency, no backpressure.
module parallelisering_core
    import parallelisering_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [W-1:0] a1, a2, a3, a4,
    input  logic [W-1:0] b1, b2, b3, b4,
    input  logic [W-1:0] c1, c2, c3, c4,
    input  logic [W-1:0] d1, d2, d3, d4,
    input  logic [W-1:0] e1, e2, e3, e4,
    input  logic [W-1:0] f1, f2, f3, f4,
    output logic [W-1:0] g1, g2, g3, g4,
    output logic [W-1:0] h1, h2, h3, h4,
    output logic [W-1:0] i1, i2, i3, i4,
    output logic         out_valid
);

    elem_t [LANES-1:0] a_v, b_v, c_v, d_v, e_v, f_v;
    elem_t [LANES-1:0] sum_v, prod_v, diff_v;
    elem_t [LANES-1:0] g_q, g_d, h_q, h_d, i_q, i_d;
    logic              out_valid_q, out_valid_d;

    assign a_v = {a4, a3, a2, a1};
    assign b_v = {b4, b3, b2, b1};
    assign c_v = {c4, c3, c2, c1};
    assign d_v = {d4, d3, d2, d1};
    assign e_v = {e4, e3, e2, e1};
    assign f_v = {f4, f3, f2, f1};

    for (genvar n = 0; n < LANES; n++) begin : g_lane
        lane_alu #(.OP(OP_ADD)) u_add (
            .x(a_v[n]), .y(b_v[n]), .r(sum_v[n])
        );
        lane_alu #(.OP(OP_MUL)) u_mul (
            .x(c_v[n]), .y(d_v[n]), .r(prod_v[n])
        );
        lane_alu #(.OP(OP_SUB)) u_sub (
            .x(e_v[n]), .y(f_v[n]), .r(diff_v[n])
        );
    end

    // Results hold whenever in_valid is low, so idle operands never leak through.
    always_comb begin
        g_d         = g_q;
        h_d         = h_q;
        i_d         = i_q;
        out_valid_d = in_valid;
        if (in_valid) begin
            g_d = sum_v;
            h_d = prod_v;
            i_d = diff_v;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            g_q         <= '0;
            h_q         <= '0;
            i_q         <= '0;
            out_valid_q <= 1'b0;
        end else begin
            g_q         <= g_d;
            h_q         <= h_d;
            i_q         <= i_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign {g4, g3, g2, g1} = g_q;
    assign {h4, h3, h2, h1} = h_q;
    assign {i4, i3, i2, i1} = i_q;
    assign out_valid        = out_valid_q;

endmodule

// File: tb/tb_parallelisering_core.sv
// Randomised and directed bench for parallelisering_core against an
// arithmetic reference model of the per-lane add / multiply / subtract.
module tb_parallelisering_core;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] a [4], b [4], c [4], d [4], e [4], f [4];
    logic [7:0] g [4], h [4], i [4];
    logic       out_valid;

    int exp_g [4], exp_h [4], exp_i [4];
    int exp_ov;
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    parallelisering_core dut (
        .clk(clk), .rst(rst), .in_valid(in_valid),
        .a1(a[0]), .a2(a[1]), .a3(a[2]), .a4(a[3]),
        .b1(b[0]), .b2(b[1]), .b3(b[2]), .b4(b[3]),
        .c1(c[0]), .c2(c[1]), .c3(c[2]), .c4(c[3]),
        .d1(d[0]), .d2(d[1]), .d3(d[2]), .d4(d[3]),
        .e1(e[0]), .e2(e[1]), .e3(e[2]), .e4(e[3]),
        .f1(f[0]), .f2(f[1]), .f3(f[2]), .f4(f[3]),
        .g1(g[0]), .g2(g[1]), .g3(g[2]), .g4(g[3]),
        .h1(h[0]), .h2(h[1]), .h3(h[2]), .h4(h[3]),
        .i1(i[0]), .i2(i[1]), .i3(i[2]), .i4(i[3]),
        .out_valid(out_valid)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int l = 0; l < 4; l++) begin
            exp_g[l] = 0;
            exp_h[l] = 0;
            exp_i[l] = 0;
        end
        exp_ov = 0;
    endtask

    task automatic compare_all(input string ph);
        for (int l = 0; l < 4; l++) begin
            check($sformatf("%s g%0d", ph, l + 1), 32'(g[l]), 32'(exp_g[l]));
            check($sformatf("%s h%0d", ph, l + 1), 32'(h[l]), 32'(exp_h[l]));
            check($sformatf("%s i%0d", ph, l + 1), 32'(i[l]), 32'(exp_i[l]));
        end
        check({ph, " out_valid"}, 32'(out_valid), 32'(exp_ov));
    endtask

    // Advance one rising edge, update the model from the sampled inputs, then compare.
    task automatic tick(input string ph);
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            if (in_valid) begin
                for (int l = 0; l < 4; l++) begin
                    exp_g[l] = (int'(a[l]) + int'(b[l])) % 256;
                    exp_h[l] = (int'(c[l]) * int'(d[l])) % 256;
                    exp_i[l] = (int'(e[l]) - int'(f[l]) + 256) % 256;
                end
            end
            exp_ov = in_valid ? 1 : 0;
        end
        #1;
        compare_all(ph);
    endtask

    task automatic rand_ops();
        for (int l = 0; l < 4; l++) begin
            a[l] = 8'($urandom);
            b[l] = 8'($urandom);
            c[l] = 8'($urandom);
            d[l] = 8'($urandom);
            e[l] = 8'($urandom);
            f[l] = 8'($urandom);
        end
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        rand_ops();
        #2;
        model_reset();
        compare_all("reset");

        @(negedge clk);
        rst = 1'b0;
        a = '{2, 4, 6, 8};  b = '{1, 2, 3, 4};
        c = '{3, 5, 7, 9};  d = '{2, 4, 6, 8};
        e = '{1, 3, 5, 7};  f = '{2, 4, 6, 8};
        in_valid = 1'b1;
        tick("vec1");
        check("vec1 h4 literal", 32'(h[3]), 32'd72);
        check("vec1 i1 literal", 32'(i[0]), 32'd255);

        @(negedge clk);
        a = '{3, 5, 7, 9};  b = '{2, 1, 2, 3};
        c = '{4, 6, 8, 8};  d = '{1, 3, 5, 7};
        e = '{2, 4, 6, 8};  f = '{2, 3, 5, 7};
        tick("vec2");
        check("vec2 h4 literal", 32'(h[3]), 32'd56);

        @(negedge clk);
        rand_ops();
        a[0] = 200; b[0] = 100;
        c[0] = 16;  d[0] = 17;
        e[0] = 0;   f[0] = 1;
        tick("wrap");
        check("wrap g1 literal", 32'(g[0]), 32'd44);
        check("wrap h1 literal", 32'(h[0]), 32'd16);
        check("wrap i1 literal", 32'(i[0]), 32'd255);

        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            in_valid = 1'b0;
            rand_ops();
            tick("idle");
        end

        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            in_valid = ($urandom_range(0, 9) < 7);
            rand_ops();
            tick("rand");
        end

        @(negedge clk);
        in_valid = 1'b1;
        rand_ops();
        tick("pre_rst");
        @(negedge clk);
        rand_ops();
        #1;
        rst = 1'b1;
        #1;
        model_reset();
        compare_all("async_rst");
        tick("rst_held");
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        tick("post_rst_idle");
        @(negedge clk);
        in_valid = 1'b1;
        rand_ops();
        tick("post_rst_valid");
        @(negedge clk);
        in_valid = 1'b0;
        tick("post_rst_drop");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
